snn_spike_decoder: RTL

- Downstream stage of the XOR spiking core.
- Observes the core's single output spike train over a fixed evaluation window and counts spikes, after a settle period that lets core membrane potentials build up.
- Produces a registered one-bit classification (spike count >= decision threshold) plus the count.
- Result is offered to the controller/testbench through a valid/ready handshake; one decision per start request.

---
 rtl/snn_spike_decoder_pkg.sv | 13 +
 rtl/snn_spike_decoder_if.sv | 23 ++
 rtl/snn_spike_decoder_sat_counter.sv | 34 +++
 rtl/snn_spike_decoder.sv | 78 +++++++
 4 files changed

// File: rtl/snn_spike_decoder_pkg.sv
// snn_pkg: shared FSM encoding and default timing constants for the spiking core blocks
package snn_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_COUNT  = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;
    localparam int DEF_COUNT_WIDTH        = 8;
    localparam int DEF_SETTLE_CYCLES      = 4;
    localparam int DEF_WINDOW_CYCLES      = 100;
    localparam int DEF_DECISION_THRESHOLD = 3;
endpackage

// File: rtl/snn_spike_decoder_if.sv
// snn_spike_decoder_if: control, spike input and result handshake bundle of the spike decoder
// master drives start/clear/spike_in/result_ready; slave drives busy/result_valid/result_bit/spike_count/overflow
interface snn_spike_decoder_if #(
    parameter int COUNT_WIDTH = snn_pkg::DEF_COUNT_WIDTH
);
    logic                   start;
    logic                   clear;
    logic                   spike_in;
    logic                   result_ready;
    logic                   busy;
    logic                   result_valid;
    logic                   result_bit;
    logic                   overflow;
    logic [COUNT_WIDTH-1:0] spike_count;
    modport master (
        output start, clear, spike_in, result_ready,
        input  busy, result_valid, result_bit, overflow, spike_count
    );
    modport slave (
        input  start, clear, spike_in, result_ready,
        output busy, result_valid, result_bit, overflow, spike_count
    );
endinterface

// File: rtl/snn_spike_decoder_sat_counter.sv
// snn_sat_counter: saturating up-counter with sync clear, enable and sticky overflow flag
// clk/rst_n clock and async active-low reset; i_clear zeroes count and flag; i_en requests +1;
// o_count current value; o_next value after this edge; o_overflow set by an increment at saturation
module snn_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic [WIDTH-1:0] o_next,
    output logic             o_overflow
);
    logic [WIDTH-1:0] r_count;
    logic             r_overflow;
    logic             w_sat;
    assign w_sat      = &r_count;
    assign o_next     = (i_en && !w_sat) ? r_count + WIDTH'(1) : r_count;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_clear) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_count    <= o_next;
            r_overflow <= r_overflow || (i_en && w_sat);
        end
    end
endmodule

// File: rtl/snn_spike_decoder.sv
// snn_spike_decoder: counts core output spikes over a window after a settle period and offers a thresholded decision
// clk/rst_n clock and async active-low reset; bus carries start/clear/spike_in/result_ready in and
// busy/result_valid/result_bit/spike_count/overflow out
module snn_spike_decoder
    import snn_pkg::*;
#(
    parameter int SETTLE_CYCLES      = DEF_SETTLE_CYCLES,
    parameter int WINDOW_CYCLES      = DEF_WINDOW_CYCLES,
    parameter int COUNT_WIDTH        = DEF_COUNT_WIDTH,
    parameter int DECISION_THRESHOLD = DEF_DECISION_THRESHOLD
) (
    input logic                clk,
    input logic                rst_n,
    snn_spike_decoder_if.slave bus
);
    localparam int MAXC = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);
    localparam logic [TW-1:0] S_LOAD = TW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [TW-1:0] W_LOAD = TW'(WINDOW_CYCLES - 1);
    localparam logic [COUNT_WIDTH:0] TH = (COUNT_WIDTH + 1)'(DECISION_THRESHOLD);
    // a threshold beyond the counter's reach can never be met
    localparam bit TH_OK = longint'(DECISION_THRESHOLD) <= (longint'(1) << COUNT_WIDTH) - 1;
    state_t                 r_state;
    logic [TW-1:0]          r_cnt;
    logic                   r_result;
    logic                   w_start;
    logic                   w_en;
    logic                   w_hit;
    logic                   w_overflow;
    logic [COUNT_WIDTH-1:0] w_count;
    logic [COUNT_WIDTH-1:0] w_next;
    assign w_start = (r_state == ST_IDLE) && bus.start;
    assign w_en    = (r_state == ST_COUNT) && bus.spike_in;
    // decide on the post-edge count so a spike on the last window edge is included
    assign w_hit   = TH_OK && ({1'b0, w_next} >= TH);
    snn_sat_counter #(.WIDTH(COUNT_WIDTH)) u_count (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (bus.clear || w_start),
        .i_en      (w_en),
        .o_count   (w_count),
        .o_next    (w_next),
        .o_overflow(w_overflow)
    );
    // r_cnt holds remaining edges minus one in the current phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_result <= 1'b0;
        end else if (bus.clear) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (bus.start) begin
                    r_state <= (SETTLE_CYCLES == 0) ? ST_COUNT : ST_SETTLE;
                    r_cnt   <= (SETTLE_CYCLES == 0) ? W_LOAD : S_LOAD;
                end
                ST_SETTLE: if (r_cnt == '0) begin
                    r_state <= ST_COUNT;
                    r_cnt   <= W_LOAD;
                end else r_cnt <= r_cnt - TW'(1);
                ST_COUNT: if (r_cnt == '0) begin
                    r_state  <= ST_HOLD;
                    r_result <= w_hit;
                end else r_cnt <= r_cnt - TW'(1);
                ST_HOLD: if (bus.result_ready) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end
    assign bus.busy         = (r_state == ST_SETTLE) || (r_state == ST_COUNT);
    assign bus.result_valid = (r_state == ST_HOLD);
    assign bus.result_bit   = r_result;
    assign bus.spike_count  = w_count;
    assign bus.overflow     = w_overflow;
endmodule
